// File: rtl/fw_cfg_shift_ctrl.sv
// Configuration shift-chain sequencer: streams a word-addressed pattern into a DUT
// scan chain on a divided clock, captures the chain output, then pulses the load strobe.
module fw_cfg_shift_ctrl #(
  parameter int CFG_BITS    = 256,
  parameter int CLK_DIV     = 4,
  parameter int LOAD_CYCLES = 4
) (
  input  logic        fw_clk,
  input  logic        fw_rst,
  input  logic        start,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [7:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic [13:0] bit_cnt,
  output logic        fw_config_clk,
  output logic        fw_config_in,
  output logic        fw_config_load,
  input  logic        fw_config_out
);

  localparam int NUM_WORDS = (CFG_BITS + 31) / 32;
  localparam int AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int DEPTH     = 1 << AW;
  localparam int DIV_MAX   = (CLK_DIV > LOAD_CYCLES) ? CLK_DIV : LOAD_CYCLES;
  localparam int DW        = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int TAIL      = CFG_BITS - 32 * (NUM_WORDS - 1);

  localparam logic [DW-1:0] CLK_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] LOAD_LAST = DW'(LOAD_CYCLES - 1);
  localparam logic [13:0]   LAST_BIT  = 14'(CFG_BITS - 1);
  localparam logic [8:0]    WORDS_9   = 9'(NUM_WORDS);
  localparam logic [8:0]    LAST_W_9  = 9'(NUM_WORDS - 1);
  localparam logic [31:0]   TAIL_MASK = (TAIL == 32) ? 32'hFFFF_FFFF : ((32'd1 << TAIL) - 32'd1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_LOAD_WAIT} state_t;

  state_t         state_reg, state_next;
  logic [DW-1:0]  div_reg, div_next;
  logic [13:0]    bit_cnt_reg, bit_cnt_next;
  logic           done_reg, done_next;
  logic           cfg_clk_reg, cfg_load_reg, busy_reg;
  logic           cap_we;
  logic [31:0]    pat_q_reg;
  logic [31:0]    rd_data_reg;

  logic [31:0]    pat_mem [DEPTH];
  logic [31:0]    cap_mem [DEPTH];

  logic [AW-1:0]  pat_raddr;
  logic [AW-1:0]  cap_waddr;
  logic           pat_we;
  logic           rd_in_range;
  logic [31:0]    rd_mask;

  always_comb begin
    state_next   = state_reg;
    div_next     = div_reg;
    bit_cnt_next = bit_cnt_reg;
    done_next    = 1'b0;
    cap_we       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next   = S_LOW;
          div_next     = '0;
          bit_cnt_next = '0;
        end
      end
      S_LOW: begin
        if (div_reg == CLK_LAST) begin
          cap_we     = 1'b1;
          state_next = S_HIGH;
          div_next   = '0;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      S_HIGH: begin
        if (div_reg == CLK_LAST) begin
          div_next = '0;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = S_LOAD_WAIT;
          end else begin
            bit_cnt_next = bit_cnt_reg + 14'd1;
            state_next   = S_LOW;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      S_LOAD_WAIT: begin
        if (div_reg == LOAD_LAST) begin
          state_next   = S_IDLE;
          div_next     = '0;
          bit_cnt_next = '0;
          done_next    = 1'b1;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pin-level strobes are registered from the next state so they never glitch.
  always_ff @(posedge fw_clk) begin
    if (fw_rst) begin
      state_reg    <= S_IDLE;
      div_reg      <= '0;
      bit_cnt_reg  <= '0;
      done_reg     <= 1'b0;
      cfg_clk_reg  <= 1'b0;
      cfg_load_reg <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      bit_cnt_reg  <= bit_cnt_next;
      done_reg     <= done_next;
      cfg_clk_reg  <= (state_next == S_HIGH);
      cfg_load_reg <= (state_next == S_IDLE);
      busy_reg     <= (state_next != S_IDLE);
    end
  end

  // The read address follows the next bit index, so the word holding the bit being
  // shifted is always present; at start this returns the word as it was before the edge.
  assign pat_raddr = bit_cnt_next[AW+4:5];
  assign pat_we    = wr_en && !fw_rst && (state_reg == S_IDLE) && ({1'b0, wr_addr} < WORDS_9);

  always_ff @(posedge fw_clk) begin
    if (pat_we) begin
      pat_mem[wr_addr[AW-1:0]] <= wr_data;
    end
    pat_q_reg <= pat_mem[pat_raddr];
  end

  assign cap_waddr = bit_cnt_reg[AW+4:5];

  always_ff @(posedge fw_clk) begin
    if (cap_we && !fw_rst) begin
      cap_mem[cap_waddr][bit_cnt_reg[4:0]] <= fw_config_out;
    end
  end

  // Capture bits beyond the chain are never written, so they are masked on readback.
  assign rd_in_range = ({1'b0, rd_addr} < WORDS_9);
  assign rd_mask     = ({1'b0, rd_addr} == LAST_W_9) ? TAIL_MASK : 32'hFFFF_FFFF;

  always_ff @(posedge fw_clk) begin
    if (fw_rst) begin
      rd_data_reg <= '0;
    end else if (rd_in_range) begin
      rd_data_reg <= cap_mem[rd_addr[AW-1:0]] & rd_mask;
    end else begin
      rd_data_reg <= '0;
    end
  end

  assign rd_data        = rd_data_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign bit_cnt        = bit_cnt_reg;
  assign fw_config_clk  = cfg_clk_reg;
  assign fw_config_load = cfg_load_reg;
  assign fw_config_in   = ((state_reg == S_LOW) || (state_reg == S_HIGH)) ?
                          pat_q_reg[bit_cnt_reg[4:0]] : 1'b0;

endmodule

// File: tb/tb_fw_cfg_shift_ctrl.sv
// Directed bench for fw_cfg_shift_ctrl: three instances (short chain, default chain,
// 40-bit chain) each looped back through a one-stage model of the DUT scan chain.
module tb_fw_cfg_shift_ctrl;

  logic fw_clk = 1'b0;
  always #5 fw_clk = ~fw_clk;

  logic [2:0]  rst_v, start_v, wr_en_v, busy_v, done_v, cclk_v, cin_v, cload_v, cout_v;
  logic [7:0]  wr_addr_a [3];
  logic [31:0] wr_data_a [3];
  logic [7:0]  rd_addr_a [3];
  logic [31:0] rd_data_a [3];
  logic [13:0] bit_cnt_a [3];

  int tests_run    = 0;
  int tests_failed = 0;

  int r_done_n, r_done1, r_done2, r_busy_first, r_busy_last, r_load_low;
  int r_edges, r_first_edge, r_last_edge, r_viol;
  logic r_busy_after;
  logic [63:0] r_bits;

  logic [31:0] pat1 [8] = '{32'hDEADBEEF, 32'h12345678, 32'h80000001, 32'hFFFFFFFF,
                            32'h00000000, 32'hA5A5A5A5, 32'h7FFFFFFF, 32'hC0FFEE01};

  fw_cfg_shift_ctrl #(.CFG_BITS(8), .CLK_DIV(2), .LOAD_CYCLES(3)) u_small (
    .fw_clk(fw_clk), .fw_rst(rst_v[0]), .start(start_v[0]), .wr_en(wr_en_v[0]),
    .wr_addr(wr_addr_a[0]), .wr_data(wr_data_a[0]), .rd_addr(rd_addr_a[0]),
    .rd_data(rd_data_a[0]), .busy(busy_v[0]), .done(done_v[0]), .bit_cnt(bit_cnt_a[0]),
    .fw_config_clk(cclk_v[0]), .fw_config_in(cin_v[0]), .fw_config_load(cload_v[0]),
    .fw_config_out(cout_v[0]));

  fw_cfg_shift_ctrl #(.CFG_BITS(256), .CLK_DIV(4), .LOAD_CYCLES(4)) u_dflt (
    .fw_clk(fw_clk), .fw_rst(rst_v[1]), .start(start_v[1]), .wr_en(wr_en_v[1]),
    .wr_addr(wr_addr_a[1]), .wr_data(wr_data_a[1]), .rd_addr(rd_addr_a[1]),
    .rd_data(rd_data_a[1]), .busy(busy_v[1]), .done(done_v[1]), .bit_cnt(bit_cnt_a[1]),
    .fw_config_clk(cclk_v[1]), .fw_config_in(cin_v[1]), .fw_config_load(cload_v[1]),
    .fw_config_out(cout_v[1]));

  fw_cfg_shift_ctrl #(.CFG_BITS(40), .CLK_DIV(1), .LOAD_CYCLES(1)) u_mid (
    .fw_clk(fw_clk), .fw_rst(rst_v[2]), .start(start_v[2]), .wr_en(wr_en_v[2]),
    .wr_addr(wr_addr_a[2]), .wr_data(wr_data_a[2]), .rd_addr(rd_addr_a[2]),
    .rd_data(rd_data_a[2]), .busy(busy_v[2]), .done(done_v[2]), .bit_cnt(bit_cnt_a[2]),
    .fw_config_clk(cclk_v[2]), .fw_config_in(cin_v[2]), .fw_config_load(cload_v[2]),
    .fw_config_out(cout_v[2]));

  // Chain model: one flop clocked by config_clk rising edges, cleared while load is high.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lb
    logic q, prev_clk;
    always @(posedge fw_clk) begin
      prev_clk <= cclk_v[gi];
      if (cload_v[gi]) q <= 1'b0;
      else if (cclk_v[gi] && !prev_clk) q <= cin_v[gi];
    end
    assign cout_v[gi] = q;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic write_word(input int idx, input logic [7:0] addr, input logic [31:0] data);
    @(negedge fw_clk);
    wr_en_v[idx] = 1'b1;
    wr_addr_a[idx] = addr;
    wr_data_a[idx] = data;
    @(negedge fw_clk);
    wr_en_v[idx] = 1'b0;
  endtask

  task automatic read_word(input int idx, input logic [7:0] addr, output logic [31:0] data);
    @(negedge fw_clk);
    rd_addr_a[idx] = addr;
    @(negedge fw_clk);
    data = rd_data_a[idx];
  endtask

  // Pulses start (sampled at the end of cycle 0) and observes cycles 1..max_cyc.
  task automatic watch_run(input int idx, input int max_cyc, input bit inject, input bit restart);
    logic prev_clk, prev_in;
    r_done_n = 0; r_done1 = 0; r_done2 = 0; r_busy_first = 0; r_busy_last = 0;
    r_load_low = 0; r_edges = 0; r_first_edge = 0; r_last_edge = 0; r_viol = 0;
    r_busy_after = 1'bx; r_bits = '0;
    @(negedge fw_clk);
    start_v[idx] = 1'b1;
    prev_clk = cclk_v[idx];
    prev_in  = cin_v[idx];
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge fw_clk);
      start_v[idx] = 1'b0;
      wr_en_v[idx] = 1'b0;
      if (busy_v[idx]) begin
        if (r_busy_first == 0) r_busy_first = cyc;
        r_busy_last = cyc;
      end
      if (!cload_v[idx]) r_load_low++;
      if (cclk_v[idx] && !prev_clk) begin
        if (r_edges < 64) r_bits[r_edges] = cin_v[idx];
        if (r_edges == 0) r_first_edge = cyc;
        r_last_edge = cyc;
        r_edges++;
      end
      if (cclk_v[idx] && (cin_v[idx] != prev_in)) r_viol++;
      if (r_done_n >= 1 && cyc == r_done1 + 1) r_busy_after = busy_v[idx];
      if (done_v[idx]) begin
        r_done_n++;
        if (r_done_n == 1) r_done1 = cyc;
        else if (r_done_n == 2) r_done2 = cyc;
        if (restart && r_done_n == 1) start_v[idx] = 1'b1;
      end
      if (inject && cyc == 20) begin
        start_v[idx]   = 1'b1;
        wr_en_v[idx]   = 1'b1;
        wr_addr_a[idx] = 8'd0;
        wr_data_a[idx] = 32'hFFFFFFFF;
      end
      prev_clk = cclk_v[idx];
      prev_in  = cin_v[idx];
      if (!restart && r_done_n >= 1 && cyc >= r_done1 + 2) break;
      if (r_done_n >= 2) break;
    end
  endtask

  initial begin
    logic [31:0] d, exp;
    bit found;
    int dn;
    rst_v = '1; start_v = '0; wr_en_v = '0;
    for (int i = 0; i < 3; i++) begin
      wr_addr_a[i] = '0; wr_data_a[i] = '0; rd_addr_a[i] = '0;
    end
    repeat (3) @(negedge fw_clk);
    rst_v = '0;
    @(negedge fw_clk);

    check_val("rst_cfg_clk",  32'(cclk_v[0]), 32'd0);
    check_val("rst_cfg_in",   32'(cin_v[0]), 32'd0);
    check_val("rst_cfg_load", 32'(cload_v[0]), 32'd1);
    check_val("rst_busy",     32'(busy_v[0]), 32'd0);
    check_val("rst_done",     32'(done_v[0]), 32'd0);
    check_val("rst_bit_cnt",  32'(bit_cnt_a[0]), 32'd0);
    check_val("rst_rd_data",  rd_data_a[0], 32'd0);

    // Short chain: 0xA5 -> 1,0,1,0,0,1,0,1; 4 cycles per bit, 3 load cycles.
    write_word(0, 8'd0, 32'h000000A5);
    watch_run(0, 60, 1'b0, 1'b0);
    check_val("s_done_cycle", 32'(r_done1), 32'd36);
    check_val("s_done_count", 32'(r_done_n), 32'd1);
    check_val("s_busy_first", 32'(r_busy_first), 32'd1);
    check_val("s_busy_last",  32'(r_busy_last), 32'd35);
    check_val("s_busy_after", 32'(r_busy_after), 32'd0);
    check_val("s_load_low",   32'(r_load_low), 32'd35);
    check_val("s_edges",      32'(r_edges), 32'd8);
    check_val("s_first_edge", 32'(r_first_edge), 32'd3);
    check_val("s_last_edge",  32'(r_last_edge), 32'd31);
    check_val("s_bits",       r_bits[31:0], 32'h000000A5);
    check_val("s_in_stable",  32'(r_viol), 32'd0);
    read_word(0, 8'd0, d);
    check_val("s_cap0", d, 32'h0000004A);
    read_word(0, 8'd1, d);
    check_val("s_cap_oor", d, 32'd0);

    // Start in the done cycle must launch a second run.
    watch_run(0, 100, 1'b0, 1'b1);
    check_val("s_restart_busy", 32'(r_busy_after), 32'd1);
    check_val("s_restart_gap",  32'(r_done2 - r_done1), 32'd36);

    // Default chain with a mid-run start and pattern write, both to be ignored.
    for (int k = 0; k < 8; k++) write_word(1, 8'(k), pat1[k]);
    watch_run(1, 2100, 1'b1, 1'b0);
    check_val("d_done_cycle", 32'(r_done1), 32'd2053);
    check_val("d_done_count", 32'(r_done_n), 32'd1);
    check_val("d_busy_last",  32'(r_busy_last), 32'd2052);
    check_val("d_edges",      32'(r_edges), 32'd256);
    check_val("d_first_edge", 32'(r_first_edge), 32'd5);
    check_val("d_last_edge",  32'(r_last_edge), 32'd2045);
    check_val("d_in_stable",  32'(r_viol), 32'd0);
    for (int k = 0; k < 8; k++) begin
      read_word(1, 8'(k), d);
      exp = (pat1[k] << 1) | ((k > 0) ? {31'd0, pat1[k-1][31]} : 32'd0);
      check_val($sformatf("d_cap%0d", k), d, exp);
    end

    write_word(1, 8'd8, 32'h12345678);
    read_word(1, 8'd200, d);
    check_val("d_rd_oor200", d, 32'd0);
    read_word(1, 8'd8, d);
    check_val("d_rd_oor8", d, 32'd0);

    // Rerun shows word0 was neither overwritten mid-run nor aliased by address 8.
    watch_run(1, 2100, 1'b0, 1'b0);
    read_word(1, 8'd0, d);
    check_val("d_rerun_cap0", d, 32'hBD5B7DDE);
    read_word(1, 8'd1, d);
    check_val("d_rerun_cap1", d, (pat1[1] << 1) | 32'd1);

    // Reset at bit 100, then a fresh full-length run.
    @(negedge fw_clk);
    start_v[1] = 1'b1;
    @(negedge fw_clk);
    start_v[1] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (bit_cnt_a[1] == 14'd100) begin
        found = 1'b1;
        break;
      end
      @(negedge fw_clk);
    end
    check_val("r_reached_100", 32'(found), 32'd1);
    rst_v[1] = 1'b1;
    @(negedge fw_clk);
    check_val("r_cfg_clk",  32'(cclk_v[1]), 32'd0);
    check_val("r_cfg_in",   32'(cin_v[1]), 32'd0);
    check_val("r_cfg_load", 32'(cload_v[1]), 32'd1);
    check_val("r_busy",     32'(busy_v[1]), 32'd0);
    check_val("r_bit_cnt",  32'(bit_cnt_a[1]), 32'd0);
    rst_v[1] = 1'b0;
    dn = 0;
    repeat (30) begin
      @(negedge fw_clk);
      if (done_v[1]) dn++;
    end
    check_val("r_no_done", 32'(dn), 32'd0);
    watch_run(1, 2100, 1'b0, 1'b0);
    check_val("r_done_cycle", 32'(r_done1), 32'd2053);
    check_val("r_busy_first", 32'(r_busy_first), 32'd1);
    check_val("r_edges",      32'(r_edges), 32'd256);

    // 40-bit chain: pattern bits 40..63 must not be shifted, capture bits 40..63 read 0.
    write_word(2, 8'd0, 32'h0F0F0F0F);
    write_word(2, 8'd1, 32'hFFFFFF5A);
    watch_run(2, 200, 1'b0, 1'b0);
    check_val("m_done_cycle", 32'(r_done1), 32'd82);
    check_val("m_busy_last",  32'(r_busy_last), 32'd81);
    check_val("m_edges",      32'(r_edges), 32'd40);
    check_val("m_first_edge", 32'(r_first_edge), 32'd2);
    check_val("m_last_edge",  32'(r_last_edge), 32'd80);
    check_val("m_bits_lo",    r_bits[31:0], 32'h0F0F0F0F);
    check_val("m_bits_hi",    r_bits[63:32], 32'h0000005A);
    check_val("m_in_stable",  32'(r_viol), 32'd0);
    read_word(2, 8'd0, d);
    check_val("m_cap0", d, 32'h1E1E1E1E);
    read_word(2, 8'd1, d);
    check_val("m_cap1", d, 32'h000000B4);
    read_word(2, 8'd2, d);
    check_val("m_cap_oor", d, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
